lsu_mem_arbiter: RTL

Shares the single data-memory port between the two LSU slots of a VLIW bundle. Each cycle it takes the EX-stage requests from both LSU lanes and issues them to memory. When both lanes need the port in the same bundle, it serializes them in slot order (lane 0, then lane 1) and raises a one-cycle structural stall to the hazard unit. It also routes 1-cycle-latency read data back to each lane's writeback and holds that data stable across stalls.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_rdata_hold.sv | 33 +++
 rtl/lsu_mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory-port arbiter: lane count, FSM states and
// the per-lane EX request bundle.
package lsu_pkg;

  localparam int NUM_LANES  = 2;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_SECOND
  } arb_state_t;

  typedef struct packed {
    logic                  rd_en;
    logic                  wr_en;
    logic [LSU_ADDR_W-1:0] rd_addr;
    logic [LSU_ADDR_W-1:0] wr_addr;
    logic [LSU_DATA_W-1:0] wr_data;
  } lane_req_t;

endpackage

// File: rtl/lsu_rdata_hold.sv
// Per-lane read-return path: forwards 1-cycle-latency memory data and keeps
// it stable until the lane's next read grant.
module lsu_rdata_hold
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_grant,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  logic              fresh_reg;
  logic [DATA_W-1:0] hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fresh_reg <= 1'b0;
      hold_reg  <= '0;
    end else begin
      fresh_reg <= rd_grant;
      if (fresh_reg) begin
        hold_reg <= mem_rdata;
      end
    end
  end

  // Data in its arrival cycle comes straight from the port, afterwards from hold.
  assign rdata = fresh_reg ? mem_rdata : hold_reg;

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port between the two LSU lanes of a bundle,
// serializing same-bundle requests in slot order with a one-cycle stall.
module lsu_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_in,
  input  logic [NUM_LANES-1:0]          lane_rd_en,
  input  logic [NUM_LANES-1:0]          lane_wr_en,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_rd_addr,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_wr_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_wr_data,
  output logic [NUM_LANES*DATA_W-1:0]   lane_rdata,
  output logic                          stall_out,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  output logic                          mem_re,
  input  logic [DATA_W-1:0]             mem_rdata
);

  lane_req_t            lane_req [NUM_LANES];
  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] rd_grant;
  logic                 conflict;
  arb_state_t           state_reg;
  arb_state_t           state_next;
  lane_req_t            sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_req[gi].rd_en   = lane_rd_en[gi];
      assign lane_req[gi].wr_en   = lane_wr_en[gi];
      assign lane_req[gi].rd_addr = LSU_ADDR_W'(lane_rd_addr[gi*ADDR_W +: ADDR_W]);
      assign lane_req[gi].wr_addr = LSU_ADDR_W'(lane_wr_addr[gi*ADDR_W +: ADDR_W]);
      assign lane_req[gi].wr_data = LSU_DATA_W'(lane_wr_data[gi*DATA_W +: DATA_W]);
      assign req[gi]              = lane_rd_en[gi] | lane_wr_en[gi];
      // A lane asserting both enables is treated as a store.
      assign rd_grant[gi]         = grant[gi] & lane_rd_en[gi] & ~lane_wr_en[gi];

      lsu_rdata_hold #(
        .DATA_W(DATA_W)
      ) u_rdata_hold (
        .clk      (clk),
        .rst      (rst),
        .rd_grant (rd_grant[gi]),
        .mem_rdata(mem_rdata),
        .rdata    (lane_rdata[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign conflict = req[0] & req[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_out  = 1'b0;
    grant      = '0;
    case (state_reg)
      ARB_IDLE: begin
        if (conflict) begin
          stall_out = 1'b1;
          if (!stall_in) begin
            grant      = 2'b01;
            state_next = ARB_SECOND;
          end
        end else if (!stall_in) begin
          grant = req;
        end
      end
      ARB_SECOND: begin
        // Lane 0 already went out; only lane 1 remains for this bundle.
        if (!stall_in) begin
          grant      = 2'b10;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
    // Nothing may reach the port while reset drops the in-flight bundle.
    if (rst) begin
      grant     = '0;
      stall_out = 1'b0;
    end
  end

  always_comb begin
    sel       = grant[1] ? lane_req[1] : lane_req[0];
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (|grant) begin
      mem_we    = sel.wr_en;
      mem_re    = sel.rd_en & ~sel.wr_en;
      mem_addr  = ADDR_W'(sel.wr_en ? sel.wr_addr : sel.rd_addr);
      mem_wdata = DATA_W'(sel.wr_data);
    end
  end

endmodule
